// File: rtl/ioctl_uploader.sv
// SPI-slave upload engine: host opens a session with RD_CMD + index byte, then clocks core data out on MISO.
// Optional UPLOADER_CRC8_EN adds a crc8 output over bytes delivered in the current session.
module ioctl_uploader #(
  parameter int         ADDR_W = 25,
  parameter logic [7:0] RD_CMD = 8'hA5
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              SPI_SCK,
  input  logic              SPI_SS2,
  input  logic              SPI_DI,
  output logic              spi_do,
  output logic              spi_do_oe,
  output logic              ioctl_upload,
  output logic [7:0]        ioctl_index,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic              ioctl_rd,
  input  logic              ioctl_rd_ack,
  input  logic [7:0]        ioctl_din,
  output logic              ioctl_underrun
`ifdef UPLOADER_CRC8_EN
  ,
  output logic [7:0]        crc8
`endif
);

  typedef enum logic [2:0] {IDLE, CMD, INDEX, DUMMY, DATA} state_t;

  state_t      state;
  logic [1:0]  sck_s, ss_s, di_s;
  logic        sck_q;
  logic [2:0]  bit_cnt;
  logic [6:0]  rx_sr;
  logic [6:0]  tx_sr;
  logic [7:0]  data_buf;
  logic        data_vld;
  logic        load_pend;
  logic        reject;

  logic        ss, di, sck_rise, sck_fall;
  logic        ack_hit, avail;
  logic [7:0]  rx_next, fetch_byte;

  assign ss         = ss_s[1];
  assign di         = di_s[1];
  assign sck_rise   = sck_s[1] & ~sck_q;
  assign sck_fall   = ~sck_s[1] & sck_q;
  assign rx_next    = {rx_sr, di};
  // An ack landing in the very cycle of a load is used directly rather than counted as an underrun.
  assign ack_hit    = ioctl_rd & ioctl_rd_ack;
  assign avail      = data_vld | ack_hit;
  assign fetch_byte = data_vld ? data_buf : ioctl_din;

`ifdef UPLOADER_CRC8_EN
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++)
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sck_s <= 2'b00;
      ss_s  <= 2'b11;
      di_s  <= 2'b00;
      sck_q <= 1'b0;
    end else begin
      sck_s <= {sck_s[0], SPI_SCK};
      ss_s  <= {ss_s[0], SPI_SS2};
      di_s  <= {di_s[0], SPI_DI};
      sck_q <= sck_s[1];
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      rx_sr          <= '0;
      tx_sr          <= '0;
      data_buf       <= '0;
      data_vld       <= 1'b0;
      load_pend      <= 1'b0;
      reject         <= 1'b0;
      spi_do         <= 1'b0;
      spi_do_oe      <= 1'b0;
      ioctl_upload   <= 1'b0;
      ioctl_index    <= '0;
      ioctl_addr     <= '0;
      ioctl_rd       <= 1'b0;
      ioctl_underrun <= 1'b0;
`ifdef UPLOADER_CRC8_EN
      crc8           <= '0;
`endif
    end else if (ss) begin
      // Deselect ends (or aborts) the session; a pending fetch is dropped and any late ack ignored.
      state        <= IDLE;
      spi_do       <= 1'b0;
      spi_do_oe    <= 1'b0;
      ioctl_upload <= 1'b0;
      ioctl_rd     <= 1'b0;
      data_vld     <= 1'b0;
      load_pend    <= 1'b0;
    end else begin
      if (ack_hit) begin
        data_buf <= ioctl_din;
        data_vld <= 1'b1;
        ioctl_rd <= 1'b0;
      end
      case (state)
        IDLE: begin
          state   <= CMD;
          bit_cnt <= '0;
          reject  <= 1'b0;
        end
        CMD: if (sck_rise) begin
          rx_sr   <= rx_next[6:0];
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7 && !reject) begin
            if (rx_next == RD_CMD) begin
              state          <= INDEX;
              ioctl_underrun <= 1'b0;
`ifdef UPLOADER_CRC8_EN
              crc8           <= '0;
`endif
            end else begin
              reject <= 1'b1;
            end
          end
        end
        INDEX: if (sck_rise) begin
          rx_sr   <= rx_next[6:0];
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            ioctl_index  <= rx_next;
            ioctl_upload <= 1'b1;
            ioctl_addr   <= '0;
            ioctl_rd     <= 1'b1;
            data_vld     <= 1'b0;
            spi_do_oe    <= 1'b1;
            spi_do       <= 1'b0;
            tx_sr        <= '0;
            state        <= DUMMY;
          end
        end
        DUMMY: if (sck_rise) begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state     <= DATA;
            load_pend <= 1'b1;
          end
        end
        DATA: begin
          if (sck_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) load_pend <= 1'b1;
          end else if (sck_fall) begin
            if (load_pend) begin
              load_pend <= 1'b0;
              if (avail) begin
                spi_do     <= fetch_byte[7];
                tx_sr      <= fetch_byte[6:0];
                data_vld   <= 1'b0;
                ioctl_addr <= ioctl_addr + ADDR_W'(1);
                ioctl_rd   <= 1'b1;
`ifdef UPLOADER_CRC8_EN
                crc8       <= crc8_step(crc8, fetch_byte);
`endif
              end else begin
                // Fill byte; the outstanding request stays as it is so the byte comes next time.
                spi_do         <= 1'b1;
                tx_sr          <= 7'h7F;
                ioctl_underrun <= 1'b1;
              end
            end else begin
              spi_do <= tx_sr[6];
              tx_sr  <= {tx_sr[5:0], 1'b0};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ioctl_uploader.sv
// Bench for ioctl_uploader: SPI host tasks, a latency-programmable core responder and a byte-stream model.
module tb_ioctl_uploader;
  localparam int AW = 4;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          SPI_SCK = 1'b0, SPI_SS2 = 1'b1, SPI_DI = 1'b0;
  logic          spi_do, spi_do_oe, ioctl_upload, ioctl_rd, ioctl_underrun;
  logic [7:0]    ioctl_index;
  logic [AW-1:0] ioctl_addr;
  logic          ack_mod = 1'b0, ack_man = 1'b0;
  logic [7:0]    din_mod = 8'h00, din_man = 8'h00;
  logic          ioctl_rd_ack;
  logic [7:0]    ioctl_din;
`ifdef UPLOADER_CRC8_EN
  logic [7:0]    crc8;
`endif

  assign ioctl_rd_ack = ack_mod | ack_man;
  assign ioctl_din    = ack_man ? din_man : din_mod;

  ioctl_uploader #(.ADDR_W(AW), .RD_CMD(8'hA5)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .SPI_SCK(SPI_SCK), .SPI_SS2(SPI_SS2), .SPI_DI(SPI_DI),
    .spi_do(spi_do), .spi_do_oe(spi_do_oe),
    .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
    .ioctl_rd(ioctl_rd), .ioctl_rd_ack(ioctl_rd_ack), .ioctl_din(ioctl_din),
    .ioctl_underrun(ioctl_underrun)
`ifdef UPLOADER_CRC8_EN
    , .crc8(crc8)
`endif
  );

  always #12 clk_sys = ~clk_sys;

  int checks = 0, failures = 0;
  int lat = 4, cnt = 0, act = 0;
  logic hold = 1'b0;
  logic [7:0] mem [16];

  // Core model: acks a pending read after `lat` cycles with the byte stored at the requested address.
  always @(negedge clk_sys) begin
    if (ack_mod) ack_mod = 1'b0;
    else if (ioctl_rd && !hold) begin
      cnt = cnt + 1;
      if (cnt >= lat) begin
        ack_mod = 1'b1;
        din_mod = mem[ioctl_addr];
        cnt = 0;
      end
    end else cnt = 0;
  end

  always @(posedge clk_sys)
    if (spi_do_oe || ioctl_upload || ioctl_rd) act <= act + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      SPI_DI = tx[i];
      #200;
      rx[i] = spi_do;
      SPI_SCK = 1'b1;
      #200;
      SPI_SCK = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic open_session(input logic [7:0] idx);
    logic [7:0] r;
    SPI_SS2 = 1'b0;
    #300;
    spi_byte(8'hA5, r);
    spi_byte(idx, r);
    #300;
  endtask

  task automatic close_session(input string tag);
    #300;
    SPI_SS2 = 1'b1;
    #300;
    chk({tag, "_upload_off"}, ioctl_upload, 0);
    chk({tag, "_oe_off"}, spi_do_oe, 0);
    chk({tag, "_rd_off"}, ioctl_rd, 0);
  endtask

  function automatic logic [7:0] crc_ref(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  // Timely session of n bytes after the index: byte 0 is the dummy, byte j>0 is mem[(j-1) mod 16],
  // and every byte's trailing edge consumes one fetch.
  task automatic run_session(input string tag, input logic [7:0] idx, input int n);
    logic [7:0] r, crc;
    open_session(idx);
    chk({tag, "_index"}, ioctl_index, idx);
    chk({tag, "_upload"}, ioctl_upload, 1);
    chk({tag, "_oe"}, spi_do_oe, 1);
    crc = 8'h00;
    for (int j = 0; j < n; j++) begin
      spi_byte(8'($urandom), r);
      chk({tag, "_miso"}, r, (j == 0) ? 8'h00 : mem[(j - 1) % 16]);
      crc = crc_ref(crc, mem[j % 16]);
    end
    #300;
    chk({tag, "_addr"}, ioctl_addr, n % 16);
    chk({tag, "_underrun"}, ioctl_underrun, 0);
`ifdef UPLOADER_CRC8_EN
    chk({tag, "_crc8"}, crc8, crc);
`endif
    close_session(tag);
  endtask

  initial begin
    logic [7:0] r;
    int a0;

    #100;
    chk("rst_do", spi_do, 0);
    chk("rst_oe", spi_do_oe, 0);
    chk("rst_upload", ioctl_upload, 0);
    chk("rst_index", ioctl_index, 0);
    chk("rst_addr", ioctl_addr, 0);
    chk("rst_rd", ioctl_rd, 0);
    chk("rst_underrun", ioctl_underrun, 0);
    reset_n = 1'b1;
    #200;
    chk("post_rst_rd", ioctl_rd, 0);
    chk("post_rst_oe", spi_do_oe, 0);

    // Directed: din = addr + 0x10, ack in 4 cycles -> 00,10,11 and final address 3.
    for (int i = 0; i < 16; i++) mem[i] = 8'(i + 16);
    lat = 4;
    run_session("basic", 8'h03, 3);

    // Wrong opcode: nothing may become active for the whole select.
    a0 = act;
    SPI_SS2 = 1'b0;
    #300;
    spi_byte(8'h3C, r);
    spi_byte(8'hA5, r);
    spi_byte(8'h12, r);
    #300;
    chk("badcmd_activity", act - a0, 0);
    chk("badcmd_index", ioctl_index, 8'h03);
    SPI_SS2 = 1'b1;
    #300;

    // Underrun: first fetch withheld past the first load.
    hold = 1'b1;
    open_session(8'h07);
    spi_byte(8'h00, r);
    chk("ur_dummy", r, 8'h00);
    #300;
    chk("ur_flag", ioctl_underrun, 1);
    chk("ur_addr_held", ioctl_addr, 0);
    chk("ur_rd_held", ioctl_rd, 1);
    hold = 1'b0;
    spi_byte(8'h00, r);
    chk("ur_fill", r, 8'hFF);
    spi_byte(8'h00, r);
    chk("ur_late_byte", r, 8'h10);
    spi_byte(8'h00, r);
    chk("ur_next_byte", r, 8'h11);
    #300;
    chk("ur_addr_final", ioctl_addr, 3);
    close_session("ur");
    chk("ur_sticky", ioctl_underrun, 1);
    open_session(8'h08);
    chk("ur_clear_on_index", ioctl_underrun, 0);
    close_session("ur2");

`ifdef UPLOADER_CRC8_EN
    mem[0] = 8'h01;
    mem[1] = 8'h02;
    lat = 2;
    open_session(8'h09);
    spi_byte(8'h00, r);
    spi_byte(8'h00, r);
    #300;
    chk("crc_0102", crc8, 8'h1B);
    close_session("crc");
`endif

    // Randomized sessions, lengths chosen to cross the address wrap.
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      lat = $urandom_range(4, 1);
      run_session("rand", 8'($urandom), (s == 0) ? 17 : $urandom_range(20, 3));
    end

    // Abort mid data byte with a fetch still outstanding.
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    lat = 2;
    open_session(8'h5A);
    spi_byte(8'h00, r);
    spi_byte(8'h00, r);
    chk("ab_byte0", r, mem[0]);
    lat = 200;
    spi_bits(8'hC3, 4, r);
    chk("ab_rd_pending", ioctl_rd, 1);
    SPI_SS2 = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("ab_upload", ioctl_upload, 0);
    chk("ab_rd", ioctl_rd, 0);
    chk("ab_oe", spi_do_oe, 0);
    chk("ab_index", ioctl_index, 8'h5A);
    @(negedge clk_sys);
    din_man = 8'h77;
    ack_man = 1'b1;
    @(negedge clk_sys);
    ack_man = 1'b0;
    repeat (4) @(negedge clk_sys);
    chk("ab_late_ack_rd", ioctl_rd, 0);
    chk("ab_late_ack_addr", ioctl_addr, 2);
    chk("ab_late_ack_upload", ioctl_upload, 0);
    lat = 3;
    run_session("after_abort", 8'h11, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ioctl_uploader.md
IOCTL_UPLOADER -- requirements
Module: ioctl_uploader

Interface
REQ-001 Parameter ADDR_W, default 25: width of ioctl_addr.
REQ-002 Parameter RD_CMD, default 8'hA5: opcode that opens an upload session.
REQ-003 clk_sys  in  1  system clock (42.666667 MHz); all logic in this domain.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SPI_SCK  in  1  host SPI clock, mode 0, ≤10 MHz, asynchronous to clk_sys.
REQ-006 SPI_SS2  in  1  host select, active-low, asynchronous.
REQ-007 SPI_DI  in  1  host MOSI.
REQ-008 spi_do  out  1  MISO data.
REQ-009 spi_do_oe  out  1  MISO drive enable; the top level tristates SPI_DO when low.
REQ-010 ioctl_upload  out  1  high while an upload session is active.
REQ-011 ioctl_index  out  8  index byte received from the host.
REQ-012 ioctl_addr  out  ADDR_W  read address for the core.
REQ-013 ioctl_rd  out  1  read request; held high until acknowledged.
REQ-014 ioctl_rd_ack  in  1  one-cycle acknowledge; ioctl_din valid in the same cycle.
REQ-015 ioctl_din  in  8  read data from the core.
REQ-016 ioctl_underrun  out  1  sticky: a data byte was due before its fetch completed.

Function
REQ-017 SPI_SCK, SPI_SS2 and SPI_DI SHALL each pass through a 2-FF synchronizer; SCK edges SHALL be detected from the synchronized value.
REQ-018 MOSI SHALL be sampled MSB-first on detected SCK rising edges; MISO SHALL change on detected falling edges.
REQ-019 FSM states SHALL be IDLE, CMD, INDEX, DUMMY, DATA; IDLE is entered whenever synchronized SS2 is high.
REQ-020 A synchronized SS2 fall SHALL move IDLE→CMD and clear the bit counter.
REQ-021 In CMD, after 8 bits: if byte == RD_CMD, go to INDEX; otherwise stay in CMD with spi_do_oe low until SS2 rises.
REQ-022 In INDEX, after 8 bits: latch ioctl_index, set ioctl_upload, set ioctl_addr = 0, assert ioctl_rd, go to DUMMY.
REQ-023 DUMMY SHALL shift out 8'h00; after its 8th rising edge, go to DATA.
REQ-024 In DATA, the prefetched byte SHALL be loaded into the shift register on the falling edge following each byte's 8th rising edge; on the same event ioctl_addr SHALL increment and ioctl_rd SHALL be asserted for the next byte.
REQ-025 If no acknowledged byte is held at load time, the block SHALL shift out 8'hFF, set ioctl_underrun, and leave the outstanding request and address unchanged.
REQ-026 ioctl_rd SHALL be high for at least 1 cycle and SHALL fall in the cycle after ioctl_rd_ack; an ack while ioctl_rd is low SHALL be ignored.
REQ-027 spi_do_oe SHALL be high only in DUMMY and DATA with SS2 low.
REQ-028 ioctl_addr SHALL wrap from all-ones to 0 without any flag.
REQ-029 An SS2 rise mid-byte SHALL abort: go to IDLE, clear ioctl_upload, drop ioctl_rd the next cycle, and discard any late ack; ioctl_index SHALL be retained.
REQ-030 ioctl_underrun SHALL clear only on reset or on entry to INDEX.

Reset
REQ-031 With reset_n low: FSM=IDLE; spi_do=0; spi_do_oe=0; ioctl_upload=0; ioctl_index=0; ioctl_addr=0; ioctl_rd=0; ioctl_underrun=0; synchronizers=idle level (SS2=1, SCK=0).
REQ-032 Reset release SHALL take effect without requiring SPI_SCK activity.

Configuration
REQ-033 Macro UPLOADER_CRC8_EN defined: add output crc8[7:0], computed as CRC-8 (poly 0x07, init 0x00, MSB-first) over the data bytes shifted in the current session, excluding FF fill; reset on entry to INDEX; updated in the cycle of each load.
REQ-034 Macro UPLOADER_CRC8_EN undefined: no crc8 port and no CRC logic.

Verification
REQ-035 SS2 low, send A5,03, then 3 more bytes; the core acks in 4 cycles with din = addr+0x10 -> MISO returns 00,10,11; ioctl_index=03; final ioctl_addr=3.
REQ-036 Send opcode 0x3C -> spi_do_oe stays 0, ioctl_upload stays 0, no ioctl_rd.
REQ-037 The core withholds ack for byte 1 across 2 byte times -> MISO returns 00,FF; ioctl_underrun=1; ioctl_addr unchanged; the later ack yields that byte next.
REQ-038 Raise SS2 after 4 bits of data byte 2 -> IDLE within 3 cycles; ioctl_upload=0; ioctl_rd=0; a later ack is ignored.
REQ-039 Set ioctl_addr start to all-ones via ADDR_W=4 with a 17-byte session -> address wraps F→0.
REQ-040 UPLOADER_CRC8_EN defined, data 01,02 -> crc8=0x1B (CRC-8 0x07, init 0x00, MSB-first).
